// File: rtl/vga_rect_scheduler_if.sv
// Host-side port of the rectangle scheduler: shadow-table writes and commit control.
interface vga_rect_scheduler_if #(
  parameter int IDX_W = 3
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [2:0]       wr_field;
  logic [9:0]       wr_data;
  logic             commit_req;
  logic             commit_pending;

  modport master (
    output wr_valid, wr_idx, wr_field, wr_data, commit_req,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_idx, wr_field, wr_data, commit_req,
    output wr_ready, commit_pending
  );
endinterface

// File: rtl/vga_rect_scheduler.sv
// Per-pixel rectangle priority scheduler with a shadow table committed to the
// active table during vertical blanking, so the display never sees torn geometry.
module vga_rect_scheduler #(
  parameter int NUM_RECTS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             pix_valid,
  input  logic             frame_start,
  vga_rect_scheduler_if.slave host,
  output logic             out_valid,
  output logic             out_hit,
  output logic [4:0]       out_colour,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_COPY
  } state_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [4:0] colour;
    logic       en;
  } rect_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RECTS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             rearm_q, rearm_d;
  logic             wr_fire;

  logic [NUM_RECTS-1:0]      hit_comb;
  logic [NUM_RECTS-1:0][4:0] col_comb;

  logic [NUM_RECTS-1:0]      hit_s1_q, hit_s1_d;
  logic [NUM_RECTS-1:0][4:0] col_s1_q, col_s1_d;
  logic                      valid_s1_q, valid_s1_d;

  logic             out_valid_q, out_valid_d;
  logic             out_hit_q, out_hit_d;
  logic [4:0]       out_colour_q, out_colour_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  assign host.wr_ready       = (state_q != ST_COPY);
  assign host.commit_pending = (state_q != ST_IDLE);
  assign wr_fire             = host.wr_valid && (state_q != ST_COPY);

  // Commit FSM: commit_req arms, the next frame_start copies one entry per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    case (state_q)
      ST_IDLE: begin
        if (host.commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_start) begin
          state_d = ST_COPY;
          cnt_d   = '0;
          rearm_d = 1'b0;
        end
      end
      ST_COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (host.commit_req) rearm_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = (rearm_q || host.commit_req) ? ST_PENDING : ST_IDLE;
          cnt_d   = '0;
          rearm_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rearm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
    end
  end

  // Each entry owns its shadow and active copy; COPY only ever moves shadow[i] to active[i].
  for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_rect
    rect_t sh_q, sh_d;
    rect_t act_q, act_d;
    logic  sel_wr;
    logic  sel_copy;

    assign sel_wr   = wr_fire && (host.wr_idx == IDX_W'(gi));
    assign sel_copy = (state_q == ST_COPY) && (cnt_q == IDX_W'(gi));

    always_comb begin
      sh_d = sh_q;
      if (sel_wr) begin
        case (host.wr_field)
          3'd0: sh_d.x0 = host.wr_data;
          3'd1: sh_d.y0 = host.wr_data;
          3'd2: sh_d.x1 = host.wr_data;
          3'd3: sh_d.y1 = host.wr_data;
          3'd4: begin
            sh_d.colour = host.wr_data[4:0];
            sh_d.en     = host.wr_data[5];
          end
          default: sh_d = sh_q;
        endcase
      end
    end

    always_comb begin
      act_d = act_q;
      if (sel_copy) act_d = sh_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q  <= '0;
        act_q <= '0;
      end else begin
        sh_q  <= sh_d;
        act_q <= act_d;
      end
    end

    assign hit_comb[gi] = act_q.en
                        && (pix_x >= act_q.x0) && (pix_x <= act_q.x1)
                        && (pix_y >= act_q.y0) && (pix_y <= act_q.y1);
    assign col_comb[gi] = act_q.colour;
  end

  // Stage 1: containment vector and colours, captured together.
  always_comb begin
    hit_s1_d   = hit_comb;
    col_s1_d   = col_comb;
    valid_s1_d = pix_valid;
  end

  // Stage 2: descending scan so the lowest set index is the last assignment and wins.
  always_comb begin
    out_hit_d    = 1'b0;
    out_idx_d    = '0;
    out_colour_d = '0;
    out_valid_d  = valid_s1_q;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit_s1_q[i]) begin
        out_hit_d    = 1'b1;
        out_idx_d    = IDX_W'(i);
        out_colour_d = col_s1_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_s1_q     <= '0;
      col_s1_q     <= '0;
      valid_s1_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_idx_q    <= '0;
      out_colour_q <= '0;
    end else begin
      hit_s1_q     <= hit_s1_d;
      col_s1_q     <= col_s1_d;
      valid_s1_q   <= valid_s1_d;
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
      out_idx_q    <= out_idx_d;
      out_colour_q <= out_colour_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_idx    = out_idx_q;
  assign out_colour = out_colour_q;

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Directed bench for vga_rect_scheduler: host writes, commit timing, priority and geometry edges.
module tb_vga_rect_scheduler;
  localparam int NUM_RECTS = 8;
  localparam int IDX_W     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic             pix_valid;
  logic             frame_start;
  logic             out_valid;
  logic             out_hit;
  logic [4:0]       out_colour;
  logic [IDX_W-1:0] out_idx;

  int n_checks = 0;
  int n_errors = 0;

  vga_rect_scheduler_if #(.IDX_W(IDX_W)) host_if ();

  vga_rect_scheduler #(
    .NUM_RECTS(NUM_RECTS),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .host       (host_if.slave),
    .out_valid  (out_valid),
    .out_hit    (out_hit),
    .out_colour (out_colour),
    .out_idx    (out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int idx, input int field, input int data);
    @(negedge clk);
    check("wr_ready_before_write", int'(host_if.wr_ready), 1);
    host_if.wr_valid = 1'b1;
    host_if.wr_idx   = idx[IDX_W-1:0];
    host_if.wr_field = field[2:0];
    host_if.wr_data  = data[9:0];
    @(negedge clk);
    host_if.wr_valid = 1'b0;
  endtask

  task automatic write_rect(input int idx, input int x0, input int y0, input int x1,
                            input int y1, input int col, input int en);
    wr(idx, 0, x0);
    wr(idx, 1, y0);
    wr(idx, 2, x1);
    wr(idx, 3, y1);
    wr(idx, 4, (en << 5) | col);
  endtask

  task automatic commit();
    @(negedge clk);
    host_if.commit_req = 1'b1;
    @(negedge clk);
    host_if.commit_req = 1'b0;
    check("pending_after_commit", int'(host_if.commit_pending), 1);
  endtask

  // Pulses frame_start and watches the 8-cycle COPY window; rearm_at>=0 pulses commit_req mid-copy.
  task automatic frame_copy(input int rearm_at, input int end_pending);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      check($sformatf("copy_pending_c%0d", i), int'(host_if.commit_pending), 1);
      check($sformatf("copy_ready_c%0d", i), int'(host_if.wr_ready), 0);
      host_if.commit_req = (i == rearm_at);
      @(negedge clk);
    end
    host_if.commit_req = 1'b0;
    check("post_copy_pending", int'(host_if.commit_pending), end_pending);
    check("post_copy_ready", int'(host_if.wr_ready), 1);
  endtask

  task automatic frame_only();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input int e_hit, input int e_idx, input int e_col);
    @(negedge clk);
    pix_x     = x[9:0];
    pix_y     = y[9:0];
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_hit"}, int'(out_hit), e_hit);
    check({tag, "_idx"}, int'(out_idx), e_idx);
    check({tag, "_colour"}, int'(out_colour), e_col);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    pix_x              = '0;
    pix_y              = '0;
    pix_valid          = 1'b0;
    frame_start        = 1'b0;
    host_if.wr_valid   = 1'b0;
    host_if.wr_idx     = '0;
    host_if.wr_field   = '0;
    host_if.wr_data    = '0;
    host_if.commit_req = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wr_ready", int'(host_if.wr_ready), 1);
    check("rst_pending", int'(host_if.commit_pending), 0);
    check("rst_out_hit", int'(out_hit), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_colour", int'(out_colour), 0);
    rst = 1'b0;
    for (int x = 0; x < 640; x += 64)
      for (int y = 0; y < 480; y += 48)
        probe("sweep", x, y, 0, 0, 0);
    probe("sweep_corner", 639, 479, 0, 0, 0);

    // Single rectangle
    write_rect(2, 10, 20, 30, 40, 7, 1);
    commit();
    frame_copy(-1, 0);
    probe("single_tl", 10, 20, 1, 2, 7);
    probe("single_br", 30, 40, 1, 2, 7);
    probe("single_left", 9, 20, 0, 0, 0);
    probe("single_out", 31, 40, 0, 0, 0);

    // Priority
    write_rect(0, 0, 0, 100, 100, 3, 1);
    write_rect(5, 50, 50, 200, 200, 9, 1);
    commit();
    frame_copy(-1, 0);
    probe("prio_75", 75, 75, 1, 0, 3);
    probe("prio_150", 150, 150, 1, 5, 9);
    probe("prio_300", 300, 300, 0, 0, 0);
    probe("prio_0_over_2", 20, 30, 1, 0, 3);

    // Deferred commit: shadow edit is invisible until committed and copied
    wr(0, 2, 40);
    frame_only();
    frame_only();
    check("defer_idle", int'(host_if.commit_pending), 0);
    probe("defer_old_a", 75, 75, 1, 0, 3);
    @(negedge clk);
    host_if.commit_req = 1'b1;
    frame_start        = 1'b1;
    @(negedge clk);
    host_if.commit_req = 1'b0;
    frame_start        = 1'b0;
    check("defer_same_cycle_pending", int'(host_if.commit_pending), 1);
    check("defer_same_cycle_ready", int'(host_if.wr_ready), 1);
    probe("defer_old_b", 75, 75, 1, 0, 3);
    frame_copy(-1, 0);
    probe("defer_new", 75, 75, 1, 5, 9);

    // Re-arm: commit during COPY leads back to PENDING and a second copy
    wr(5, 4, 9);
    commit();
    frame_copy(2, 1);
    probe("rearm_disabled", 75, 75, 0, 0, 0);
    check("rearm_still_pending", int'(host_if.commit_pending), 1);
    wr(5, 4, 32 + 9);
    frame_copy(-1, 0);
    probe("rearm_second_copy", 75, 75, 1, 5, 9);

    // Reset in the middle of COPY
    commit();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midcopy_rst_pending", int'(host_if.commit_pending), 0);
    check("midcopy_rst_ready", int'(host_if.wr_ready), 1);
    check("midcopy_rst_hit", int'(out_hit), 0);
    check("midcopy_rst_valid", int'(out_valid), 0);
    rst = 1'b0;
    probe("midcopy_rst_e5", 75, 75, 0, 0, 0);
    probe("midcopy_rst_e2", 10, 20, 0, 0, 0);
    probe("midcopy_rst_e0", 0, 0, 0, 0, 0);

    // Degenerate geometry and ignored field codes
    write_rect(1, 40, 10, 39, 20, 4, 1);
    write_rect(3, 639, 479, 639, 479, 12, 1);
    commit();
    frame_copy(-1, 0);
    probe("degen_inverted_a", 40, 15, 0, 0, 0);
    probe("degen_inverted_b", 39, 15, 0, 0, 0);
    probe("point_hit", 639, 479, 1, 3, 12);
    probe("point_left", 638, 479, 0, 0, 0);
    probe("point_above", 639, 478, 0, 0, 0);
    probe("point_right", 640, 479, 0, 0, 0);
    wr(3, 6, 0);
    wr(3, 7, 0);
    commit();
    frame_copy(-1, 0);
    probe("field6_unchanged", 639, 479, 1, 3, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_rect_scheduler.md
Name: vga_rect_scheduler

Overview:
- Schedules a table of NUM_RECTS rectangle fill regions onto the pixel stream; per pixel, returns the colour index of the highest-priority enabled rectangle containing (pix_x, pix_y).
- A host loads rectangles into a shadow table through a valid/ready port.
- A commit request copies the shadow table into the active table, one entry per clock, starting at the next frame_start, so the display never sees torn geometry.
- Output feeds a vga_colour instance downstream, which decodes the colour and applies its transparency mask.

Parameters:
- NUM_RECTS, 8, number of rectangle entries; entry 0 has highest priority.
- IDX_W, 3, index width; must satisfy 2^IDX_W >= NUM_RECTS.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- pix_x  in  10  current x, connected to pix_x.
- pix_y  in  10  current y, connected to pix_y.
- pix_valid  in  1  pixel coordinates are valid this cycle.
- frame_start  in  1  single-cycle pulse at the start of vertical blanking.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
- wr_idx  in  IDX_W  target entry.
- wr_field  in  3  0=x0, 1=y0, 2=x1, 3=y1, 4=attr.
- wr_data  in  10  field value; for attr, [4:0]=colour and [5]=enable.
- commit_req  in  1  single-cycle pulse requesting a shadow-to-active commit.
- commit_pending  out  1  high while in the PENDING or COPY state.
- out_valid  out  1  pix_valid delayed by 2 cycles.
- out_hit  out  1  an enabled rectangle contains the pixel.
- out_colour  out  5  colour of the winning entry; 0 when there is no hit.
- out_idx  out  IDX_W  index of the winning entry; 0 when there is no hit.

Behaviour:
- Reset: all shadow and active entries cleared (coordinates 0, colour 0, enable 0); FSM to IDLE; wr_ready=1; commit_pending=0; out_valid=0, out_hit=0, out_colour=0, out_idx=0; pipeline registers cleared.
- Reset mid-COPY or mid-PENDING: abandons the operation and returns to IDLE; the active table is cleared, not partially copied.
- Shadow writes:
  - Take effect on the accepting edge.
  - wr_field values 5-7 are accepted with no effect.
  - wr_idx >= NUM_RECTS is accepted with no effect.
  - Only wr_data bits [5:0] are used for attr.
- FSM, IDLE:
  - commit_req -> PENDING.
  - frame_start is ignored.
  - If commit_req and frame_start arrive in the same cycle, go to PENDING; the copy waits for the next frame_start.
- FSM, PENDING:
  - wr_ready=1; writes are allowed and are included in the copy.
  - frame_start -> COPY with copy counter = 0.
  - Repeated commit_req has no effect.
- FSM, COPY:
  - wr_ready=0.
  - Each cycle, shadow[cnt] is copied to active[cnt] and cnt increments.
  - After entry NUM_RECTS-1 is copied: go to PENDING if a re-arm flag is set, else IDLE. COPY therefore lasts exactly NUM_RECTS cycles.
  - commit_req during COPY sets the re-arm flag.
  - frame_start during COPY is ignored.
- commit_pending = (state != IDLE).
- Pixel pipeline, latency 2 cycles, runs every cycle regardless of FSM state:
  - Stage 1 registers a hit vector: hit[i] = enable[i] & (pix_x >= x0[i]) & (pix_x <= x1[i]) & (pix_y >= y0[i]) & (pix_y <= y1[i]).
  - All comparisons are unsigned 10-bit with inclusive bounds.
  - Stage 1 also registers pix_valid.
  - Stage 2 priority-encodes the hit vector (lowest index wins) and registers out_hit, out_idx, out_colour and out_valid.
  - Colour is sampled from the active table in stage 1 alongside the hit vector.
- Degenerate geometry:
  - x0 > x1 or y0 > y1: the entry never hits.
  - x0 = x1 and y0 = y1: a single-pixel hit.
  - Coordinates are 10 bits wide with no wrap-around.
- When pix_valid=0, the hit is still computed, but out_valid=0 and downstream ignores the result.
- The active table changes only during COPY, which starts at the start of vblank; NUM_RECTS must not exceed the blanking length.

Test Plan:
- Reset: assert rst for 2 cycles -> wr_ready=1, commit_pending=0, out_hit=0; sweep the full frame -> out_hit=0 everywhere.
- Single rectangle: write entry 2 = (10,20,30,40), colour 7, enable 1; pulse commit_req, then frame_start.
  - commit_pending stays high for 8 COPY cycles, then drops; wr_ready=0 exactly during those 8 cycles.
  - Pixel (10,20) gives out_hit=1, out_idx=2, out_colour=7, 2 cycles after input.
  - Pixels (9,20) and (31,40) give out_hit=0.
- Priority: entry 0 = (0,0,100,100), colour 3; entry 5 = (50,50,200,200), colour 9; commit.
  - (75,75) -> idx 0, colour 3.
  - (150,150) -> idx 5, colour 9.
  - (300,300) -> no hit.
- Deferred commit: edit entry 0 in shadow without commit_req -> output unchanged across 2 frames.
  - commit_req in the same cycle as frame_start -> still the old geometry until after the next frame_start's COPY.
- Re-arm and reset: commit_req during COPY -> FSM returns to PENDING after the copy and copies again at the next frame_start.
  - rst asserted at COPY cycle 3 -> IDLE, all outputs 0, no hits.
- Degenerate: entry with x0=40, x1=39 -> never hits.
  - Entry (639,479,639,479) -> hit only at pixel (639,479).
  - Write with wr_field=6 -> accepted, table unchanged.
